// File: rtl/saradc_11b_result_decoder.sv
// Decodes 13 redundant SAR comparator decisions into a 12-bit binary result.
// Latency: result valid on the edge after the 13th accepted decision.
// Backpressure: result held in HOLD until res_ready_i; a start in that cycle chains straight into CONV.
module saradc_11b_result_decoder #(
    parameter int N_DEC  = 13,
    parameter int RES_W  = 12,
    parameter int CHNR_W = 5,
    parameter int N_CH   = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [CHNR_W-1:0] chnr_i,
    input  logic              dec_valid_i,
    input  logic              dec_i,
    input  logic              abort_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [RES_W-1:0]  res_o,
    output logic [CHNR_W-1:0] res_chnr_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int IDX_W = $clog2(N_DEC);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N_DEC - 1);
    localparam logic [CHNR_W:0]  NCH_L   = (CHNR_W + 1)'(N_CH);

    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    state_t              state_q, state_d;
    logic [RES_W-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CHNR_W-1:0]   chnr_q, chnr_d;
    logic [RES_W-1:0]    res_q, res_d;
    logic [CHNR_W-1:0]   res_chnr_q, res_chnr_d;
    logic                res_valid_q, res_valid_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic                chnr_ok;
    logic [RES_W-1:0]    acc_add;

    // Redundant (non-binary) capacitor weights; the sum of all 13 is exactly 2048.
    function automatic logic [RES_W-1:0] cap_weight(input logic [IDX_W-1:0] idx);
        case (idx)
            IDX_W'(12): cap_weight = RES_W'(824);
            IDX_W'(11): cap_weight = RES_W'(496);
            IDX_W'(10): cap_weight = RES_W'(296);
            IDX_W'(9):  cap_weight = RES_W'(176);
            IDX_W'(8):  cap_weight = RES_W'(108);
            IDX_W'(7):  cap_weight = RES_W'(64);
            IDX_W'(6):  cap_weight = RES_W'(36);
            IDX_W'(5):  cap_weight = RES_W'(22);
            IDX_W'(4):  cap_weight = RES_W'(12);
            IDX_W'(3):  cap_weight = RES_W'(7);
            IDX_W'(2):  cap_weight = RES_W'(4);
            IDX_W'(1):  cap_weight = RES_W'(2);
            IDX_W'(0):  cap_weight = RES_W'(1);
            default:    cap_weight = '0;
        endcase
    endfunction

    assign chnr_ok = ({1'b0, chnr_i} < NCH_L);
    assign acc_add = acc_q + cap_weight(idx_q);

    // Next-state, accumulator and registered-output logic.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        chnr_d     = chnr_q;
        res_d      = res_q;
        res_chnr_d = res_chnr_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (chnr_ok) begin
                        state_d = CONV;
                        acc_d   = '0;
                        idx_d   = IDX_TOP;
                        chnr_d  = chnr_i;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CONV: begin
                err_d = start_i;
                // Abort wins over a decision arriving in the same cycle.
                if (abort_i) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    idx_d   = IDX_TOP;
                end else if (dec_valid_i) begin
                    if (dec_i) begin
                        acc_d = acc_add;
                    end
                    if (idx_q == '0) begin
                        state_d    = HOLD;
                        idx_d      = IDX_TOP;
                        res_d      = dec_i ? acc_add : acc_q;
                        res_chnr_d = chnr_q;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            HOLD: begin
                if (res_ready_i) begin
                    if (start_i && chnr_ok) begin
                        state_d = CONV;
                        acc_d   = '0;
                        idx_d   = IDX_TOP;
                        chnr_d  = chnr_i;
                    end else begin
                        state_d = IDLE;
                        err_d   = start_i;
                    end
                end else begin
                    err_d = start_i;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        res_valid_d = (state_d == HOLD);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= IDX_TOP;
            chnr_q      <= '0;
            res_q       <= '0;
            res_chnr_q  <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            chnr_q      <= chnr_d;
            res_q       <= res_d;
            res_chnr_q  <= res_chnr_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_o       = res_q;
    assign res_chnr_o  = res_chnr_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule
